ripple_carry_adder: RTL and testbench
=====================================

# ripple_carry_adder

Parameterised two's-complement ripple-carry adder, 32 bits by default. It forms `A + B + Cin` combinationally through a chain of full-adder cells and reports carry-out and signed overflow. It also captures the result in a registered output stage for downstream pipelined consumers. It is the basic add/subtract datapath element of the ALU; subtraction is done by the caller presenting `~B` with `Cin = 1`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and sum width in bits; must be at least 2.

Ports:
- `clk`  in  1  clock; only the registered outputs use it.
- `rst`  in  1  asynchronous, active-high reset; clears the registered outputs only.
- `A`  in  WIDTH  first operand, two's complement.
- `B`  in  WIDTH  second operand, two's complement.
- `Cin`  in  1  carry into bit 0.
- `Sum`  out  WIDTH  combinational sum, `(A + B + Cin) mod 2^WIDTH`.
- `Cout`  out  1  combinational carry out of bit WIDTH-1.
- `Overflow`  out  1  combinational signed overflow; present only with `RCA_OVERFLOW_EN`.
- `SumReg`  out  WIDTH  `Sum` registered on `clk`.
- `CoutReg`  out  1  `Cout` registered on `clk`.
- `OvfReg`  out  1  `Overflow` registered on `clk`; present only with `RCA_OVERFLOW_EN`.

## Operation
- Bit i uses one full adder: `s[i] = A[i]^B[i]^c[i]` and `c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i])`.
- `c[0] = Cin` and `Cout = c[WIDTH]`.
- The carry chain is a strict ripple chain: no lookahead and no use of a behavioural `+` for the full width.
- `Overflow = c[WIDTH] ^ c[WIDTH-1]`. Equivalently, it is set when the operands have equal signs and `Sum[WIDTH-1]` differs from them.
- `Cout` is the unsigned carry. It is independent of `Overflow`; for example, `100 + (-90)` gives `Cout = 1` and `Overflow = 0`.
- Wrap-around is modular and never saturates: `0x7FFFFFFF + 1` gives `0x80000000`.
- All operand values are legal; there are no error states and no state machine.
- Unknown or X inputs propagate to the outputs; no masking is applied.

## Timing
- `Sum`, `Cout` and `Overflow` are purely combinational and settle within one propagation delay of any change on `A`, `B` or `Cin`. No clock edge is needed.
- The worst-case path is `Cin` or bit 0 through to `Cout`/`Overflow`, across WIDTH cells.
- `SumReg`, `CoutReg` and `OvfReg` sample the combinational outputs on every rising edge of `clk`, giving 1-cycle latency. There is no enable.
- While `rst = 1`, the registered outputs are forced to 0 immediately, without waiting for a clock edge. The first capture happens on the first rising `clk` edge after `rst` deasserts.
- Reset never affects the combinational outputs.

## Configuration
- Macro: `RCA_OVERFLOW_EN`.
- When defined: the `Overflow` and `OvfReg` ports exist and behave as described above.
- When undefined: both ports and the overflow register are removed. `Sum`, `Cout`, `SumReg` and `CoutReg` are unchanged.

## Structure
- Shared package `rca_pkg` holds the `RCA_DEFAULT_WIDTH = 32` constant and the `rca_word_t` typedef (logic [RCA_DEFAULT_WIDTH-1:0]).
- Sub-module `full_adder`, with ports `a, b, cin -> s, cout`, is instantiated WIDTH times in a generate loop.
- The top level holds the carry vector `c[WIDTH:0]`, the overflow XOR and the output registers.

## Test plan
- `A = 0x7FFFFFFF`, `B = 1`, `Cin = 0` -> `Sum = 0x80000000`, `Cout = 0`, `Overflow = 1`.
- `A = 0x80000000`, `B = 0xFFFFFFFF`, `Cin = 0` -> `Sum = 0x7FFFFFFF`, `Cout = 1`, `Overflow = 1`.
- Mixed signs and `Cin`, each checked for `Overflow = 0`:
  - `100 + (-90)`, `Cin = 0` -> `Sum = 10`, `Cout = 1`.
  - `100 + 90` -> `190`.
  - `-100 + (-90)` -> `-190` (`0xFFFFFF42`).
- With `Cin`:
  - `10 + (-90) + 1` -> `-79` (`0xFFFFFFB1`).
  - `10 + (-90) + 0` -> `-80`.
  - `3456 + (-8347) + 1` -> `-4890` (`0xFFFFECE6`).
- Registered path:
  - Apply `A = 100`, `B = 90` and clock once -> `SumReg = 190`.
  - Assert `rst` between clock edges -> `SumReg`, `CoutReg` and `OvfReg` go to 0 at once, while `Sum` stays 190.
- Exhaustive sweep at `WIDTH = 4` over all `A`, `B` and `Cin` -> `{Cout, Sum}` equals the 5-bit arithmetic sum, and `Overflow` matches the signed range check.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry adder datapath.
// Used by ripple_carry_adder and its testbench.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 32;

    typedef logic [RCA_DEFAULT_WIDTH-1:0] rca_word_t;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder cell.
// This cell is one link in the ripple carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterised ripple-carry adder with a registered output stage.
// Optional signed overflow outputs are enabled by defining RCA_OVERFLOW_EN.
module ripple_carry_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
`ifdef RCA_OVERFLOW_EN
    output logic             Overflow,
    output logic             OvfReg,
`endif
    output logic [WIDTH-1:0] SumReg,
    output logic             CoutReg
);

    logic [WIDTH:0] c;

    assign c[0] = Cin;
    assign Cout = c[WIDTH];

    // Strict ripple: each cell's carry feeds the next, no lookahead.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        full_adder u_fa (
            .a    (A[gi]),
            .b    (B[gi]),
            .cin  (c[gi]),
            .s    (Sum[gi]),
            .cout (c[gi+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SumReg  <= '0;
            CoutReg <= 1'b0;
        end else begin
            SumReg  <= Sum;
            CoutReg <= Cout;
        end
    end

`ifdef RCA_OVERFLOW_EN
    assign Overflow = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OvfReg <= 1'b0;
        end else begin
            OvfReg <= Overflow;
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard testbench for ripple_carry_adder (32-bit and 4-bit instances).
// Overflow checks are active when RCA_OVERFLOW_EN is defined.
module tb_ripple_carry_adder;
    import rca_pkg::*;

    typedef struct {
        int        kind;
        rca_word_t sum;
        logic      cout;
        logic      ovf;
        string     name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rca_word_t a = '0;
    rca_word_t b = '0;
    logic      cin = 1'b0;
    rca_word_t sum;
    rca_word_t sum_reg;
    logic      cout;
    logic      cout_reg;

    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic [3:0] sum4;
    logic [3:0] sum4_reg;
    logic       cout4;
    logic       cout4_reg;

`ifdef RCA_OVERFLOW_EN
    logic ovf;
    logic ovf_reg;
    logic ovf4;
    logic ovf4_reg;
`endif

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    event chk;

    always #5 clk = ~clk;

    ripple_carry_adder dut (
        .clk      (clk),
        .rst      (rst),
        .A        (a),
        .B        (b),
        .Cin      (cin),
        .Sum      (sum),
        .Cout     (cout),
`ifdef RCA_OVERFLOW_EN
        .Overflow (ovf),
        .OvfReg   (ovf_reg),
`endif
        .SumReg   (sum_reg),
        .CoutReg  (cout_reg)
    );

    ripple_carry_adder #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .A        (a4),
        .B        (b4),
        .Cin      (cin4),
        .Sum      (sum4),
        .Cout     (cout4),
`ifdef RCA_OVERFLOW_EN
        .Overflow (ovf4),
        .OvfReg   (ovf4_reg),
`endif
        .SumReg   (sum4_reg),
        .CoutReg  (cout4_reg)
    );

    function automatic exp_t mk(int k, rca_word_t s, logic co, logic ov,
                                string nm);
        exp_t e;
        e.kind = k;
        e.sum  = s;
        e.cout = co;
        e.ovf  = ov;
        e.name = nm;
        return e;
    endfunction

    task automatic check(exp_t e);
        rca_word_t gs;
        logic      gc;
        logic      go;
        go = e.ovf;
        case (e.kind)
            0: begin
                gs = sum;
                gc = cout;
`ifdef RCA_OVERFLOW_EN
                go = ovf;
`endif
            end
            1: begin
                gs = sum_reg;
                gc = cout_reg;
`ifdef RCA_OVERFLOW_EN
                go = ovf_reg;
`endif
            end
            default: begin
                gs = {28'd0, sum4};
                gc = cout4;
`ifdef RCA_OVERFLOW_EN
                go = ovf4;
`endif
            end
        endcase
        total++;
        if (gs !== e.sum || gc !== e.cout || go !== e.ovf) begin
            bad++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     e.name, gs, gc, go, e.sum, e.cout, e.ovf);
        end
    endtask

    // Monitor: drains the scoreboard whenever stimulus marks outputs settled.
    initial begin
        forever begin
            @(chk);
            while (q.size() > 0) check(q.pop_front());
        end
    end

    task automatic comb32(rca_word_t x, rca_word_t y, logic ci,
                          rca_word_t s, logic co, logic ov, string nm);
        a   = x;
        b   = y;
        cin = ci;
        #1;
        q.push_back(mk(0, s, co, ov, nm));
        ->chk;
        #1;
    endtask

    task automatic post(exp_t e);
        q.push_back(e);
        ->chk;
        #0;
    endtask

    initial begin
        a = 32'd100;
        b = 32'd90;
        #7;
        post(mk(1, 32'd0, 1'b0, 1'b0, "reset_state"));

        comb32(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "max_plus_one");
        comb32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, "min_minus_one");
        comb32(32'd100, 32'hFFFF_FFA6, 1'b0, 32'd10, 1'b1, 1'b0, "100_m90");
        comb32(32'd100, 32'd90, 1'b0, 32'd190, 1'b0, 1'b0, "100_p90");
        comb32(32'hFFFF_FF9C, 32'hFFFF_FFA6, 1'b0, 32'hFFFF_FF42, 1'b1, 1'b0, "m100_m90");
        comb32(32'd10, 32'hFFFF_FFA6, 1'b1, 32'hFFFF_FFB1, 1'b0, 1'b0, "10_m90_c1");
        comb32(32'd10, 32'hFFFF_FFA6, 1'b0, 32'hFFFF_FFB0, 1'b0, 1'b0, "10_m90_c0");
        comb32(32'd3456, 32'hFFFF_DF65, 1'b1, 32'hFFFF_ECE6, 1'b0, 1'b0, "3456_m8347_c1");
        comb32(32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "full_ripple");
        comb32(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "zero");
        comb32(32'd5, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_5_7");
        comb32(32'd7, 32'hFFFF_FFFA, 1'b1, 32'd2, 1'b1, 1'b0, "sub_7_5");

        @(negedge clk);
        rst = 1'b0;
        a   = 32'd100;
        b   = 32'd90;
        cin = 1'b0;
        @(posedge clk);
        #1;
        post(mk(1, 32'd190, 1'b0, 1'b0, "reg_capture"));

        @(negedge clk);
        a = 32'h7FFF_FFFF;
        b = 32'h1;
        #1;
        q.push_back(mk(1, 32'd190, 1'b0, 1'b0, "reg_latency"));
        post(mk(0, 32'h8000_0000, 1'b0, 1'b1, "comb_before_edge"));
        @(posedge clk);
        #1;
        post(mk(1, 32'h8000_0000, 1'b0, 1'b1, "reg_ovf_capture"));

        @(negedge clk);
        a = 32'd100;
        b = 32'd90;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.push_back(mk(1, 32'd0, 1'b0, 1'b0, "async_reset_reg"));
        post(mk(0, 32'd190, 1'b0, 1'b0, "reset_keeps_comb"));
        @(posedge clk);
        #1;
        post(mk(1, 32'd0, 1'b0, 1'b0, "reset_held_edge"));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        post(mk(1, 32'd190, 1'b0, 1'b0, "first_capture"));

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    int full;
                    int sx;
                    int sy;
                    int ssum;
                    rca_word_t fw;
                    full = x + y + ci;
                    fw   = full;
                    sx   = (x > 7) ? x - 16 : x;
                    sy   = (y > 7) ? y - 16 : y;
                    ssum = sx + sy + ci;
                    a4   = x[3:0];
                    b4   = y[3:0];
                    cin4 = ci[0];
                    #1;
                    post(mk(2, {28'd0, fw[3:0]}, fw[4],
                            (ssum > 7) || (ssum < -8),
                            $sformatf("w4_%0d_%0d_%0d", x, y, ci)));
                    #1;
                end
            end
        end

        for (int i = 0; i < 100 && q.size() > 0; i++) #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got pending=%0d want pending=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
